// File: rtl/key_event_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_decoder_if
//  Description : Bundle between the key debouncer / event consumer and the
//                key event decoder. The decoder uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_event_decoder_if;
  logic [3:0] key_value;   // debounced press code, active low, one-cycle pulse
  logic [3:0] key_raw;     // raw key levels, active low
  logic       evt_valid;   // one-cycle event strobe
  logic [1:0] evt_key;     // index of key that produced the event
  logic [1:0] evt_type;    // 0 SHORT, 1 LONG, 2 REPEAT
  logic       busy;        // a key is being tracked

  modport master (
    output key_value, key_raw,
    input  evt_valid, evt_key, evt_type, busy
  );

  modport slave (
    input  key_value, key_raw,
    output evt_valid, evt_key, evt_type, busy
  );
endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_decoder
//  Description : Classifies a debounced key press as SHORT, LONG or
//                auto-REPEAT and emits one-cycle event pulses. One key is
//                tracked at a time; release is confirmed by REL_CYC
//                consecutive high cycles on the raw level of that key.
//                REP_CYC must be at least 2 so events never abut.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
  parameter int CNT_W    = 26,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int REL_CYC  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  key_event_decoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

  // Terminal counts: every counter compare is an equality against PARAM-1
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] rel_q, rel_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_key_q, evt_key_d;
  logic [1:0]       evt_type_q, evt_type_d;
  logic             busy_q;

  logic [1:0]       press_idx;
  logic             rel_level;
  logic             rel_done;
  logic [CNT_W-1:0] rel_next;

  // Lowest-numbered active-low bit of the press code wins
  always_comb begin
    press_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.key_value[i]) press_idx = 2'(i);
    end
  end

  // Release detector on the tracked key; any low level restarts the count
  assign rel_level = bus.key_raw[idx_q];
  assign rel_done  = rel_level && (rel_q == REL_LAST);
  assign rel_next  = rel_level ? rel_q + CNT_ONE : '0;

  // Next-state, counter and event decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    rel_d       = rel_q;
    evt_valid_d = 1'b0;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_value != 4'b1111) begin
          idx_d   = press_idx;
          state_d = ST_HELD;
          hold_d  = '0;
          rep_d   = '0;
          rel_d   = '0;
        end
      end
      ST_HELD: begin
        hold_d = hold_q + CNT_ONE;
        rel_d  = rel_next;
        if (rel_done) begin
          // Release beats a coincident LONG threshold
          state_d     = ST_IDLE;
          evt_valid_d = 1'b1;
          evt_key_d   = idx_q;
          evt_type_d  = EVT_SHORT;
          hold_d      = '0;
          rel_d       = '0;
        end else if (hold_q == LONG_LAST) begin
          state_d     = ST_REPEAT;
          evt_valid_d = 1'b1;
          evt_key_d   = idx_q;
          evt_type_d  = EVT_LONG;
          hold_d      = '0;
          rep_d       = '0;
        end
      end
      ST_REPEAT: begin
        rep_d = rep_q + CNT_ONE;
        rel_d = rel_next;
        if (rel_done) begin
          // Release ends auto-repeat silently, even on a repeat boundary
          state_d = ST_IDLE;
          rep_d   = '0;
          rel_d   = '0;
        end else if (rep_q == REP_LAST) begin
          evt_valid_d = 1'b1;
          evt_key_d   = idx_q;
          evt_type_d  = EVT_REPEAT;
          rep_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        rep_d   = '0;
        rel_d   = '0;
      end
    endcase
  end

  // State and registered outputs; busy follows the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      hold_q      <= '0;
      rep_q       <= '0;
      rel_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= 2'd0;
      evt_type_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      rel_q       <= rel_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_key   = evt_key_q;
  assign bus.evt_type  = evt_type_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_decoder
//  Description : Directed self-checking bench for key_event_decoder with
//                LONG_CYC=20, REP_CYC=5, REL_CYC=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  key_event_decoder_if bus();

  key_event_decoder #(
    .CNT_W    (26),
    .LONG_CYC (20),
    .REP_CYC  (5),
    .REL_CYC  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset dominates a pending press; idle outputs all zero afterwards
  task automatic test_reset();
    rst = 1'b1;
    bus.key_value = 4'b1110;
    bus.key_raw   = 4'b1111;
    repeat (3) tick();
    vec_cnt++;
    if ({bus.evt_valid, bus.busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_hold: {valid,busy} got %b want 00", {bus.evt_valid, bus.busy});
    end
    bus.key_value = 4'b1111;
    rst = 1'b0;
    repeat (2) tick();
    vec_cnt++;
    if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_idle: {valid,key,type,busy} got %b want 000000",
               {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy});
    end
  endtask

  // Key 2 held 8 cycles then released -> single SHORT, busy drops with it
  task automatic test_short();
    logic [5:0] exp;
    bus.key_raw   = 4'b1011;
    bus.key_value = 4'b1011;
    tick();
    bus.key_value = 4'b1111;
    for (int n = 1; n <= 12; n++) begin
      if (n >= 9) bus.key_raw = 4'b1111;
      tick();
      if (n < 11)       exp = {1'b0, 2'd0, 2'd0, 1'b1};
      else if (n == 11) exp = {1'b1, 2'd2, 2'd0, 1'b0};
      else              exp = {1'b0, 2'd2, 2'd0, 1'b0};
      vec_cnt++;
      if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== exp) begin
        err_cnt++;
        $display("FAIL short n=%0d: {valid,key,type,busy} got %b want %b", n,
                 {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy}, exp);
      end
    end
  endtask

  // Key 0 held 40 cycles: LONG at 20, REPEAT at 25/30/35/40, silent release
  task automatic test_long_repeat();
    logic exp_v;
    logic [1:0] exp_t;
    bus.key_raw   = 4'b1110;
    bus.key_value = 4'b1110;
    tick();
    bus.key_value = 4'b1111;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_v = (n >= 20) && ((n - 20) % 5 == 0);
      exp_t = (n == 20) ? 2'd1 : 2'd2;
      vec_cnt++;
      if ({bus.evt_valid, bus.busy} !== {exp_v, 1'b1}) begin
        err_cnt++;
        $display("FAIL long_repeat n=%0d: {valid,busy} got %b want %b", n,
                 {bus.evt_valid, bus.busy}, {exp_v, 1'b1});
      end
      if (exp_v) begin
        vec_cnt++;
        if ({bus.evt_key, bus.evt_type} !== {2'd0, exp_t}) begin
          err_cnt++;
          $display("FAIL long_repeat_evt n=%0d: {key,type} got %b want %b", n,
                   {bus.evt_key, bus.evt_type}, {2'd0, exp_t});
        end
      end
    end
    bus.key_raw = 4'b1111;
    for (int n = 41; n <= 50; n++) begin
      tick();
      vec_cnt++;
      if ({bus.evt_valid, bus.busy} !== {1'b0, (n < 43)}) begin
        err_cnt++;
        $display("FAIL long_release n=%0d: {valid,busy} got %b want %b", n,
                 {bus.evt_valid, bus.busy}, {1'b0, (n < 43)});
      end
    end
    vec_cnt++;
    if ({bus.evt_key, bus.evt_type} !== {2'd0, 2'd2}) begin
      err_cnt++;
      $display("FAIL hold_last: {key,type} got %b want 0010", {bus.evt_key, bus.evt_type});
    end
  endtask

  // Multi-bit code picks key 1; a press code while busy is ignored
  task automatic test_priority();
    logic [5:0] exp;
    bus.key_raw   = 4'b1101;
    bus.key_value = 4'b0101;
    tick();
    bus.key_value = 4'b1110;
    for (int n = 1; n <= 7; n++) begin
      if (n == 2) bus.key_value = 4'b1111;
      if (n == 4) bus.key_raw = 4'b1111;
      tick();
      if (n < 6)       exp = {1'b0, 2'd0, 2'd2, 1'b1};
      else if (n == 6) exp = {1'b1, 2'd1, 2'd0, 1'b0};
      else             exp = {1'b0, 2'd1, 2'd0, 1'b0};
      vec_cnt++;
      if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== exp) begin
        err_cnt++;
        $display("FAIL priority n=%0d: {valid,key,type,busy} got %b want %b", n,
                 {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy}, exp);
      end
    end
  endtask

  // Short glitches never release; release coinciding with a REPEAT slot wins
  task automatic test_bounce();
    logic exp_v;
    bus.key_raw   = 4'b0111;
    bus.key_value = 4'b0111;
    tick();
    bus.key_value = 4'b1111;
    for (int n = 1; n <= 27; n++) begin
      if (n <= 20)      bus.key_raw[3] = ((n % 4) == 1) || ((n % 4) == 2);
      else if (n <= 22) bus.key_raw[3] = 1'b0;
      else              bus.key_raw[3] = 1'b1;
      tick();
      exp_v = (n == 20);
      vec_cnt++;
      if ({bus.evt_valid, bus.busy} !== {exp_v, (n < 25)}) begin
        err_cnt++;
        $display("FAIL bounce n=%0d: {valid,busy} got %b want %b", n,
                 {bus.evt_valid, bus.busy}, {exp_v, (n < 25)});
      end
      if (exp_v) begin
        vec_cnt++;
        if ({bus.evt_key, bus.evt_type} !== {2'd3, 2'd1}) begin
          err_cnt++;
          $display("FAIL bounce_long: {key,type} got %b want 1101", {bus.evt_key, bus.evt_type});
        end
      end
    end
  endtask

  // Release on the LONG threshold gives SHORT; next press accepted immediately
  task automatic test_back_to_back();
    logic [5:0] exp;
    bus.key_raw   = 4'b1110;
    bus.key_value = 4'b1110;
    tick();
    bus.key_value = 4'b1111;
    for (int n = 1; n <= 20; n++) begin
      bus.key_raw[0] = (n >= 18);
      tick();
      exp = (n == 20) ? {1'b1, 2'd0, 2'd0, 1'b0} : {1'b0, 2'd3, 2'd1, 1'b1};
      vec_cnt++;
      if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== exp) begin
        err_cnt++;
        $display("FAIL tie n=%0d: {valid,key,type,busy} got %b want %b", n,
                 {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy}, exp);
      end
    end
    bus.key_raw   = 4'b1110;
    bus.key_value = 4'b1110;
    tick();
    bus.key_value = 4'b1111;
    vec_cnt++;
    if ({bus.evt_valid, bus.busy} !== 2'b01) begin
      err_cnt++;
      $display("FAIL b2b_accept: {valid,busy} got %b want 01", {bus.evt_valid, bus.busy});
    end
    bus.key_raw = 4'b1111;
    for (int n = 1; n <= 3; n++) begin
      tick();
      exp = (n == 3) ? {1'b1, 2'd0, 2'd0, 1'b0} : {1'b0, 2'd0, 2'd0, 1'b1};
      vec_cnt++;
      if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== exp) begin
        err_cnt++;
        $display("FAIL b2b_short n=%0d: {valid,key,type,busy} got %b want %b", n,
                 {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy}, exp);
      end
    end
  endtask

  // Reset mid-hold aborts silently; the following press decodes normally
  task automatic test_reset_abort();
    logic [5:0] exp;
    bus.key_raw   = 4'b1110;
    bus.key_value = 4'b1110;
    tick();
    bus.key_value = 4'b1111;
    repeat (10) tick();
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.evt_valid, bus.busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL abort_async: {valid,busy} got %b want 00", {bus.evt_valid, bus.busy});
    end
    bus.key_raw = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      vec_cnt++;
      if ({bus.evt_valid, bus.busy} !== 2'b00) begin
        err_cnt++;
        $display("FAIL abort_quiet n=%0d: {valid,busy} got %b want 00", n,
                 {bus.evt_valid, bus.busy});
      end
    end
    bus.key_raw   = 4'b1101;
    bus.key_value = 4'b1101;
    tick();
    bus.key_value = 4'b1111;
    for (int n = 1; n <= 5; n++) begin
      if (n == 3) bus.key_raw = 4'b1111;
      tick();
      exp = (n == 5) ? {1'b1, 2'd1, 2'd0, 1'b0} : {1'b0, 2'd0, 2'd0, 1'b1};
      vec_cnt++;
      if ({bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy} !== exp) begin
        err_cnt++;
        $display("FAIL after_abort n=%0d: {valid,key,type,busy} got %b want %b", n,
                 {bus.evt_valid, bus.evt_key, bus.evt_type, bus.busy}, exp);
      end
    end
  endtask

  initial begin
    bus.key_value = 4'b1111;
    bus.key_raw   = 4'b1111;
    test_reset();
    test_short();
    test_long_repeat();
    test_priority();
    test_bounce();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
